// File: rtl/aidan_mcnay_piso.sv
// aidan_mcnay_piso: parallel-in serial-out shifter with valid/ready handshake.
// A word is accepted in IDLE, then streamed one bit per accepted cycle.
// Build option: define AIDAN_MCNAY_PISO_LSB_FIRST_EN for LSB-first bit order
// (default build streams MSB first).
`ifndef AIDAN_MCNAY_PISO_SV
`define AIDAN_MCNAY_PISO_SV

module aidan_mcnay_piso #(
  parameter int unsigned nbits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [nbits-1:0] load_data,
  output logic             load_rdy,
  input  logic             out_rdy,
  output logic             out_valid,
  output logic             data_out,
  output logic             out_last
);

  localparam int unsigned CW = $clog2(nbits);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [CW-1:0] LAST_IDX = CW'(nbits - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [0:0]       state_q, state_d;
  logic [nbits-1:0] sreg_q,  sreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;

  logic load_fire;
  logic bit_accept;
  logic cur_bit;
  logic [nbits-1:0] sreg_shifted;

  // The bit on the wire always sits at the outgoing end of the shift register.
`ifdef AIDAN_MCNAY_PISO_LSB_FIRST_EN
  assign cur_bit      = sreg_q[0];
  assign sreg_shifted = {1'b0, sreg_q[nbits-1:1]};
`else
  assign cur_bit      = sreg_q[nbits-1];
  assign sreg_shifted = {sreg_q[nbits-2:0], 1'b0};
`endif

  assign load_rdy   = (state_q == IDLE);
  assign out_valid  = (state_q == SHIFT);
  assign out_last   = out_valid && (cnt_q == LAST_IDX);
  assign data_out   = out_valid && cur_bit;

  assign load_fire  = load_en && load_rdy;
  assign bit_accept = out_valid && out_rdy;

  // Next-state logic: capture on load, advance only on an accepted bit.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load_fire) begin
          sreg_d  = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_accept) begin
          if (out_last) begin
            // Counter parks at the last index; it is cleared on the next load.
            state_d = IDLE;
          end else begin
            cnt_d  = cnt_q + ONE;
            sreg_d = sreg_shifted;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`endif

// File: tb/tb_aidan_mcnay_piso.sv
// Directed testbench for aidan_mcnay_piso with nbits=8.
// Expected serial sequences are hand-written per build; the
// AIDAN_MCNAY_PISO_LSB_FIRST_EN build selects the LSB-first sequences.
module tb_aidan_mcnay_piso;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_en;
  logic [7:0] load_data;
  logic       load_rdy;
  logic       out_rdy;
  logic       out_valid;
  logic       data_out;
  logic       out_last;

  int unsigned n_tests  = 0;
  int unsigned n_failed = 0;

  aidan_mcnay_piso #(.nbits(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_data (load_data),
    .load_rdy  (load_rdy),
    .out_rdy   (out_rdy),
    .out_valid (out_valid),
    .data_out  (data_out),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".load_rdy"},  32'(load_rdy),  32'd1);
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, ".data_out"},  32'(data_out),  32'd0);
    check_eq({tag, ".out_last"},  32'(out_last),  32'd0);
  endtask

  task automatic check_bit(input string tag, input int k, input logic exp_bit);
    check_eq($sformatf("%s.b%0d.valid", tag, k), 32'(out_valid), 32'd1);
    check_eq($sformatf("%s.b%0d.rdy",   tag, k), 32'(load_rdy),  32'd0);
    check_eq($sformatf("%s.b%0d.data",  tag, k), 32'(data_out),  32'(exp_bit));
    check_eq($sformatf("%s.b%0d.last",  tag, k), 32'(out_last),  32'(k == 7));
  endtask

  // Load `word`, then walk the expected serial sequence seq[7] first.
  // stall_at: bit index held with out_rdy=0 for 3 extra cycles (-1 = none).
  // busy_at : bit index during which load_en is pulsed with 8'hFF (-1 = none).
  // stop_at : number of bits observed before returning early (8 = full word).
  task automatic run_word(input string tag, input logic [7:0] word, input logic [7:0] seq,
                          input int stall_at, input int busy_at, input int stop_at);
    load_en   = 1'b1;
    load_data = word;
    out_rdy   = 1'b1;
    tick();
    load_en   = 1'b0;
    load_data = 8'h00;
    for (int k = 0; k < stop_at; k++) begin
      check_bit(tag, k, seq[7-k]);
      if (k == stall_at) begin
        out_rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          check_bit($sformatf("%s.stall%0d", tag, s), k, seq[7-k]);
        end
        out_rdy = 1'b1;
      end
      if (k == busy_at) begin
        load_en   = 1'b1;
        load_data = 8'hFF;
      end
      tick();
      load_en = 1'b0;
    end
    if (stop_at == 8) check_idle({tag, ".after"});
  endtask

  logic [7:0] seq_a5, seq_f0, seq_3c, seq_ff, seq_01;

  initial begin
`ifdef AIDAN_MCNAY_PISO_LSB_FIRST_EN
    seq_a5 = 8'b1010_0101;
    seq_f0 = 8'b0000_1111;
    seq_3c = 8'b0011_1100;
    seq_ff = 8'b1111_1111;
    seq_01 = 8'b1000_0000;
`else
    seq_a5 = 8'b1010_0101;
    seq_f0 = 8'b1111_0000;
    seq_3c = 8'b0011_1100;
    seq_ff = 8'b1111_1111;
    seq_01 = 8'b0000_0001;
`endif
    reset     = 1'b1;
    load_en   = 1'b0;
    load_data = 8'h00;
    out_rdy   = 1'b0;

    // Reset held for two cycles.
    tick();
    tick();
    reset = 1'b0;
    check_idle("reset");

    // Continuous streaming of 8'hA5.
    run_word("a5", 8'hA5, seq_a5, -1, -1, 8);

    // Backpressure after the second bit.
    run_word("f0", 8'hF0, seq_f0, 1, -1, 8);

    // Load attempt while busy must be ignored.
    run_word("3c", 8'h3C, seq_3c, -1, 3, 8);

    // Mid-word reset after four bits.
    run_word("ff", 8'hFF, seq_ff, -1, -1, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("midrst");
    run_word("01", 8'h01, seq_01, -1, -1, 8);

    // Reset wins over a simultaneous load.
    reset     = 1'b1;
    load_en   = 1'b1;
    load_data = 8'h81;
    tick();
    reset   = 1'b0;
    load_en = 1'b0;
    check_idle("rstprio");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
